// File: rtl/flash_responder_if.sv
// flash_responder_if
//   Bundles the serial flash pins and the byte-wide user-side signals of
//   flash_responder. clk and reset stay plain ports on the module.
//
//   slave  modport : the responder itself (samples the pins, drives spi_q and
//                    the user-side byte outputs).
//   master modport : whatever drives the link and the reply bytes (flash
//                    controller plus user model, or a testbench).
//
//   Signals:
//     spi_c, spi_s_n, spi_d : serial clock, active-low select, master data
//     spi_q, spi_q_oe       : responder data and its output enable
//     tx_data               : next reply byte, captured at byte boundaries
//     status                : status byte (used only with FLASH_RESP_STATUS_EN)
//     rx_data, rx_idx       : last received byte and its position in the frame
//     rx_valid              : one-cycle pulse when rx_data updates
//     sel_start, sel_end    : one-cycle frame start / end pulses
interface flash_responder_if;
  logic       spi_c;
  logic       spi_s_n;
  logic       spi_d;
  logic       spi_q;
  logic       spi_q_oe;
  logic [7:0] tx_data;
  logic [7:0] status;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rx_idx;
  logic       sel_start;
  logic       sel_end;

  modport slave (
    input  spi_c, spi_s_n, spi_d, tx_data, status,
    output spi_q, spi_q_oe, rx_data, rx_valid, rx_idx, sel_start, sel_end
  );

  modport master (
    output spi_c, spi_s_n, spi_d, tx_data, status,
    input  spi_q, spi_q_oe, rx_data, rx_valid, rx_idx, sel_start, sel_end
  );
endinterface

// File: rtl/flash_responder.sv
// flash_responder
//   Device-side end of a bit-level SPI flash link (mode 0, MSB first).
//   The serial pins are oversampled on clk through SYNC_STAGES flops plus a
//   history flop for edge detection. Received bits are assembled into bytes
//   on rising spi_c edges; reply bits are shifted out on falling spi_c edges,
//   with a fresh reply byte loaded at every byte boundary.
//
//   Parameters:
//     SYNC_STAGES : synchroniser depth on spi_c, spi_s_n, spi_d (minimum 2)
//
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high reset
//     bus   : flash_responder_if.slave (pins + byte-wide user side)
//
//   Optional feature (macro FLASH_RESP_STATUS_EN):
//     when the first byte of a frame is 8'h05, every later reply byte of that
//     frame is taken from bus.status instead of bus.tx_data. Without the
//     macro bus.status is ignored.
module flash_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  flash_responder_if.slave   bus
);

  localparam int PIN_C   = 0;
  localparam int PIN_S_N = 1;
  localparam int PIN_D   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    WAIT_DESEL
  } state_t;

  // ---------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------
  logic [2:0] pin_raw;
  logic [2:0] pin_sync;

  assign pin_raw = {bus.spi_d, bus.spi_s_n, bus.spi_c};

  // Chains clear to 0 so that, after reset, s_n reads as "selected" until the
  // real pin level has propagated; WAIT_DESEL therefore only leaves once the
  // master has genuinely deselected.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_raw[gi]};
        end
      end
      assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic c_sync;
  logic s_n_sync;
  logic d_sync;

  assign c_sync   = pin_sync[PIN_C];
  assign s_n_sync = pin_sync[PIN_S_N];
  assign d_sync   = pin_sync[PIN_D];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t     state_reg;
  logic       c_hist_reg;
  logic       s_n_hist_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] byte_cnt_reg;
  logic [7:0] rx_shift_reg;
  logic [7:0] tx_shift_reg;
  logic       spi_q_reg;
  logic       spi_q_oe_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic [7:0] rx_idx_reg;
  logic       sel_start_reg;
  logic       sel_end_reg;

  logic c_rise;
  logic c_fall;
  logic s_n_rise;
  logic s_n_fall;

  assign c_rise   =  c_sync   & ~c_hist_reg;
  assign c_fall   = ~c_sync   &  c_hist_reg;
  assign s_n_rise =  s_n_sync & ~s_n_hist_reg;
  assign s_n_fall = ~s_n_sync &  s_n_hist_reg;

  // Byte completed by the current rising edge (valid when bit_cnt_reg == 7).
  logic [7:0] rx_complete;
  assign rx_complete = {rx_shift_reg[6:0], d_sync};

  logic [7:0] byte_cnt_next;
  assign byte_cnt_next = (byte_cnt_reg == 8'hFF) ? 8'hFF : byte_cnt_reg + 8'd1;

  // Source of the reply byte loaded at each byte boundary after the first.
  logic [7:0] reply_byte;

`ifdef FLASH_RESP_STATUS_EN
  logic stat_mode_reg;
  assign reply_byte = stat_mode_reg ? bus.status : bus.tx_data;
`else
  logic unused_status;
  assign unused_status = ^bus.status;
  assign reply_byte    = bus.tx_data;
`endif

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= WAIT_DESEL;
      c_hist_reg    <= 1'b0;
      s_n_hist_reg  <= 1'b0;
      bit_cnt_reg   <= 3'd0;
      byte_cnt_reg  <= 8'd0;
      rx_shift_reg  <= 8'd0;
      tx_shift_reg  <= 8'd0;
      spi_q_reg     <= 1'b0;
      spi_q_oe_reg  <= 1'b0;
      rx_data_reg   <= 8'd0;
      rx_valid_reg  <= 1'b0;
      rx_idx_reg    <= 8'd0;
      sel_start_reg <= 1'b0;
      sel_end_reg   <= 1'b0;
`ifdef FLASH_RESP_STATUS_EN
      stat_mode_reg <= 1'b0;
`endif
    end else begin
      c_hist_reg    <= c_sync;
      s_n_hist_reg  <= s_n_sync;
      rx_valid_reg  <= 1'b0;
      sel_start_reg <= 1'b0;
      sel_end_reg   <= 1'b0;

      case (state_reg)
        // Ignore everything until the master is seen deselected; this drops
        // any frame that was already running when reset was released.
        WAIT_DESEL: begin
          if (s_n_sync) begin
            state_reg <= IDLE;
          end
        end

        IDLE: begin
          if (s_n_fall) begin
            state_reg     <= ACTIVE;
            sel_start_reg <= 1'b1;
            bit_cnt_reg   <= 3'd0;
            byte_cnt_reg  <= 8'd0;
            tx_shift_reg  <= bus.tx_data;
            spi_q_reg     <= bus.tx_data[7];
            spi_q_oe_reg  <= 1'b1;
`ifdef FLASH_RESP_STATUS_EN
            stat_mode_reg <= 1'b0;
`endif
          end
        end

        ACTIVE: begin
          // Deselect takes priority over a coincident clock edge.
          if (s_n_rise) begin
            state_reg    <= IDLE;
            sel_end_reg  <= 1'b1;
            spi_q_oe_reg <= 1'b0;
            spi_q_reg    <= 1'b0;
          end else if (c_rise) begin
            rx_shift_reg <= rx_complete;
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_data_reg  <= rx_complete;
              rx_idx_reg   <= byte_cnt_reg;
              rx_valid_reg <= 1'b1;
              byte_cnt_reg <= byte_cnt_next;
`ifdef FLASH_RESP_STATUS_EN
              if (byte_cnt_reg == 8'd0 && rx_complete == 8'h05) begin
                stat_mode_reg <= 1'b1;
              end
`endif
            end
          end else if (c_fall) begin
            if (bit_cnt_reg != 3'd0) begin
              tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
              spi_q_reg    <= tx_shift_reg[6];
            end else begin
              // Eighth falling edge: start the next reply byte.
              tx_shift_reg <= reply_byte;
              spi_q_reg    <= reply_byte[7];
            end
          end
        end

        default: begin
          state_reg <= WAIT_DESEL;
        end
      endcase
    end
  end

  assign bus.spi_q     = spi_q_reg;
  assign bus.spi_q_oe  = spi_q_oe_reg;
  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.rx_idx    = rx_idx_reg;
  assign bus.sel_start = sel_start_reg;
  assign bus.sel_end   = sel_end_reg;

endmodule

// File: tb/tb_flash_responder.sv
// tb_flash_responder
//   Self-checking bench for flash_responder. Drives the serial link as an
//   SPI mode-0 master with slow, legal timing (6 clk per spi_c phase), logs
//   every rx_valid byte from a monitor, and compares against hand-computed
//   expectations from a frame table plus directed corner-case sequences.
module tb_flash_responder;

  logic clk;
  logic reset;

  flash_responder_if bus ();

  flash_responder #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FLASH_RESP_STATUS_EN
  localparam logic [7:0] STAT_REPLY = 8'h03;
`else
  localparam logic [7:0] STAT_REPLY = 8'hEE;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: count pulses and log received bytes.
  int         sel_start_cnt = 0;
  int         sel_end_cnt   = 0;
  int         rx_cnt        = 0;
  logic [7:0] rx_log_data [512];
  logic [7:0] rx_log_idx  [512];
  int         rd_ptr        = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.sel_start === 1'b1) sel_start_cnt++;
      if (bus.sel_end === 1'b1) sel_end_cnt++;
      if (bus.rx_valid === 1'b1) begin
        if (rx_cnt < 512) begin
          rx_log_data[rx_cnt] = bus.rx_data;
          rx_log_idx[rx_cnt]  = bus.rx_idx;
        end
        rx_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Consume one logged received byte and compare data and index.
  task automatic pop_rx(input string name, input logic [7:0] exp_data, input logic [7:0] exp_idx);
    n_checks++;
    if (rd_ptr >= rx_cnt || rd_ptr >= 512) begin
      n_fail++;
      $display("FAIL %s: no rx_valid seen, expected data 0x%0h idx %0d", name, exp_data, exp_idx);
    end else begin
      if (rx_log_data[rd_ptr] !== exp_data || rx_log_idx[rd_ptr] !== exp_idx) begin
        n_fail++;
        $display("FAIL %s: got data 0x%0h idx %0d, expected data 0x%0h idx %0d",
                 name, rx_log_data[rd_ptr], rx_log_idx[rd_ptr], exp_data, exp_idx);
      end else begin
        $display("ok   %s: data 0x%0h idx %0d", name, exp_data, exp_idx);
      end
      rd_ptr++;
    end
  endtask

  task automatic select_frame();
    bus.spi_s_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic deselect_frame();
    bus.spi_s_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Clock nbits bits of mosi (MSB first) and capture the reply bits. When
  // update_tx is set, tx_data takes tx_after on the cycle rx_valid is seen.
  task automatic send_bits(input logic [7:0] mosi, input int nbits, input logic [7:0] tx_after,
                           input bit update_tx, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_d = mosi[7-i];
      @(negedge clk);
      miso[7-i] = bus.spi_q;
      bus.spi_c = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (update_tx && bus.rx_valid === 1'b1) bus.tx_data = tx_after;
      end
      bus.spi_c = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] tx_first;   // tx_data at select (first byte of a frame only)
    logic [7:0] mosi;       // byte sent by the master
    logic [7:0] tx_next;    // tx_data presented after this byte's rx_valid
    logic [7:0] exp_miso;   // byte the master must read back
    logic [7:0] exp_idx;    // expected rx_idx
    bit         last;       // deselect after this byte
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  logic [7:0] miso;
  int         ss0, se0, rx0;

  initial begin
    // Frame A: write A5, 3C; reply 9F then 12.
    vecs[0] = '{8'h9F, 8'hA5, 8'h12, 8'h9F, 8'd0, 1'b0};
    vecs[1] = '{8'h00, 8'h3C, 8'h00, 8'h12, 8'd1, 1'b1};
    // Frame B: three bytes with a fresh reply each time.
    vecs[2] = '{8'h5A, 8'h81, 8'hC3, 8'h5A, 8'd0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'hC3, 8'd1, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'd2, 1'b1};
    // Frame C: READ STATUS, then two reads.
    vecs[5] = '{8'hEE, 8'h05, 8'hEE, 8'hEE, 8'd0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 8'hEE, STAT_REPLY, 8'd1, 1'b0};

    bus.spi_c   = 1'b0;
    bus.spi_s_n = 1'b1;
    bus.spi_d   = 1'b0;
    bus.tx_data = 8'h00;
    bus.status  = 8'h03;
    reset       = 1'b1;
    repeat (5) @(negedge clk);

    check("reset_spi_q",     {31'd0, bus.spi_q},     32'd0);
    check("reset_spi_q_oe",  {31'd0, bus.spi_q_oe},  32'd0);
    check("reset_rx_data",   {24'd0, bus.rx_data},   32'd0);
    check("reset_rx_valid",  {31'd0, bus.rx_valid},  32'd0);
    check("reset_rx_idx",    {24'd0, bus.rx_idx},    32'd0);
    check("reset_sel_start", {31'd0, bus.sel_start}, 32'd0);
    check("reset_sel_end",   {31'd0, bus.sel_end},   32'd0);

    reset = 1'b0;
    repeat (6) @(negedge clk);

    // ---- table-driven frames ----
    for (int v = 0; v < NV; v++) begin
      if (v == 0 || vecs[v-1].last) begin
        bus.tx_data = vecs[v].tx_first;
        ss0 = sel_start_cnt;
        se0 = sel_end_cnt;
        select_frame();
        check($sformatf("v%0d_oe_in_frame", v), {31'd0, bus.spi_q_oe}, 32'd1);
      end
      send_bits(vecs[v].mosi, 8, vecs[v].tx_next, 1'b1, miso);
      check($sformatf("v%0d_miso", v), {24'd0, miso}, {24'd0, vecs[v].exp_miso});
      pop_rx($sformatf("v%0d_rx", v), vecs[v].mosi, vecs[v].exp_idx);
      if (vecs[v].last) begin
        deselect_frame();
        check($sformatf("v%0d_oe_after", v), {31'd0, bus.spi_q_oe}, 32'd0);
        check($sformatf("v%0d_q_after", v), {31'd0, bus.spi_q}, 32'd0);
        check($sformatf("v%0d_sel_start_cnt", v), sel_start_cnt - ss0, 32'd1);
        check($sformatf("v%0d_sel_end_cnt", v), sel_end_cnt - se0, 32'd1);
      end
    end
    // Frame C continues: third byte also from the status source.
    send_bits(8'h00, 8, 8'hEE, 1'b1, miso);
    check("stat_byte2_miso", {24'd0, miso}, {24'd0, STAT_REPLY});
    pop_rx("stat_byte2_rx", 8'h00, 8'd2);
    deselect_frame();

    // ---- partial frame: 5 bits then deselect ----
    rx0 = rx_cnt;
    se0 = sel_end_cnt;
    select_frame();
    send_bits(8'hF0, 5, 8'h00, 1'b0, miso);
    deselect_frame();
    check("partial_no_rx", rx_cnt - rx0, 32'd0);
    check("partial_sel_end", sel_end_cnt - se0, 32'd1);
    bus.tx_data = 8'h00;
    select_frame();
    send_bits(8'h81, 8, 8'h00, 1'b0, miso);
    pop_rx("after_partial_rx", 8'h81, 8'd0);
    deselect_frame();

    // ---- reset mid-frame, released while selected ----
    select_frame();
    send_bits(8'hAA, 3, 8'h00, 1'b0, miso);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    ss0 = sel_start_cnt;
    se0 = sel_end_cnt;
    rx0 = rx_cnt;
    send_bits(8'h5A, 8, 8'h00, 1'b0, miso);
    check("rstmid_oe", {31'd0, bus.spi_q_oe}, 32'd0);
    check("rstmid_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("rstmid_no_sel_start", sel_start_cnt - ss0, 32'd0);
    check("rstmid_no_rx", rx_cnt - rx0, 32'd0);
    deselect_frame();
    check("rstmid_no_sel_end", sel_end_cnt - se0, 32'd0);
    rd_ptr = rx_cnt;
    bus.tx_data = 8'h6B;
    select_frame();
    check("rstmid_resume_sel_start", sel_start_cnt - ss0, 32'd1);
    send_bits(8'h42, 8, 8'h00, 1'b0, miso);
    check("rstmid_resume_miso", {24'd0, miso}, 32'h6B);
    pop_rx("rstmid_resume_rx", 8'h42, 8'd0);
    deselect_frame();

    // ---- 300-byte frame: rx_idx saturates at 255 ----
    rd_ptr = rx_cnt;
    rx0 = rx_cnt;
    select_frame();
    for (int n = 0; n < 300; n++) begin
      logic [7:0] b;
      b = n[7:0] ^ 8'h5C;
      send_bits(b, 8, 8'h00, 1'b0, miso);
      pop_rx($sformatf("long_b%0d", n), b, (n > 255) ? 8'd255 : n[7:0]);
    end
    deselect_frame();
    check("long_rx_count", rx_cnt - rx0, 32'd300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_responder.md
# flash_responder

Bit-level SPI flash responder: the device-side end of the serial flash link driven by the flash bit-level controller (`c`/`s_n`/`d` in, `q` out). It oversamples the serial pins on the system clock, deserialises command/address/data bytes, and serialises reply bytes in SPI mode 0 with MSB first. It sits between the flash pins and a byte-wide user model, such as a flash emulator or a loopback test device. It is used for simulation benches and FPGA-to-FPGA bring-up.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on `spi_c`, `spi_s_n` and `spi_d`. Minimum 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `spi_c`  in  1  serial clock from the master; asynchronous to `clk`.
- `spi_s_n`  in  1  chip select, active-low; asynchronous.
- `spi_d`  in  1  master-to-responder data; asynchronous.
- `spi_q`  out  1  responder-to-master data.
- `spi_q_oe`  out  1  output enable for `spi_q`; high while selected.
- `tx_data`  in  8  next reply byte; captured at byte boundaries.
- `status`  in  8  status byte; used only with `FLASH_RESP_STATUS_EN`.
- `rx_data`  out  8  last completed received byte.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `rx_idx`  out  8  position of `rx_data` within the frame, 0-based, saturating at 255.
- `sel_start`  out  1  one-cycle pulse on frame start.
- `sel_end`  out  1  one-cycle pulse on frame end.

## Operation
- Each pin passes through `SYNC_STAGES` flops, plus one history flop used for edge detection.
- States: `IDLE`, `ACTIVE`, `WAIT_DESEL`.
- `IDLE`:
  - On a synchronised `s_n` falling edge: go to `ACTIVE`.
  - Pulse `sel_start`, set `bit_cnt`=0 and `byte_cnt`=0.
  - Load `tx_data` into the tx shifter, drive `spi_q`=`tx_data[7]`, set `spi_q_oe`=1.
- `ACTIVE`, on a synchronised `c` rising edge:
  - Shift the synchronised `d` into the rx shifter LSB.
  - Increment `bit_cnt` (3 bits, wraps).
  - When `bit_cnt` was 7: `rx_data` takes the completed byte, `rx_idx`=`byte_cnt`, pulse `rx_valid`, set `byte_cnt`=min(`byte_cnt`+1, 255).
- `ACTIVE`, on a synchronised `c` falling edge:
  - When `bit_cnt`≠0: shift the tx shifter left and drive its new MSB.
  - When `bit_cnt`=0 (byte boundary, 8th falling edge): load the reply byte and drive its bit 7.
- `ACTIVE`, on a synchronised `s_n` rising edge: go to `IDLE`, pulse `sel_end`, set `spi_q_oe`=0 and `spi_q`=0. Any partial byte is discarded and produces no `rx_valid`.
- Simultaneous `s_n` rise and `c` edge in the same cycle: deselect wins and the `c` edge is ignored.
- Reply byte source: `tx_data`, except in the status mode described under Configuration.
- Reset:
  - All outputs go to 0: `spi_q`=0, `spi_q_oe`=0, `rx_data`=0, `rx_valid`=0, `rx_idx`=0, `sel_start`=0, `sel_end`=0.
  - The next state is `WAIT_DESEL`, which ignores all traffic until synchronised `s_n`=1, then goes to `IDLE`.
  - Consequence: a frame already in progress when reset is released is ignored entirely, and no `sel_start` or `sel_end` is emitted for it.
- `c` edges while in `IDLE` or `WAIT_DESEL` are ignored.

## Timing
- Pin-to-action latency is `SYNC_STAGES`+1 `clk` cycles, i.e. 3 by default. This applies to `rx_valid`, `sel_start`, `sel_end` and each `spi_q` update.
- `spi_c` must stay high ≥ `SYNC_STAGES`+2 `clk` cycles and low ≥ `SYNC_STAGES`+2 `clk` cycles. Slower is always legal.
- `spi_d` must be stable from before the `c` rising edge until at least `SYNC_STAGES` `clk` cycles after it.
- Master sampling window:
  - `spi_q` is valid from `SYNC_STAGES`+1 cycles after a `c` fall until the next `c` fall.
  - The first bit is valid `SYNC_STAGES`+1 cycles after the `s_n` fall.
  - The master must not raise `c` earlier than this.
- Reply handshake:
  - The user presents the next reply byte after `rx_valid`.
  - `tx_data` is sampled on the cycle the 8th falling edge is detected, which is ≥ 2 `clk` after `rx_valid` under the legal `c` timing.
  - `tx_data` must therefore be valid within 1 cycle of `rx_valid`.
  - First-byte `tx_data` is sampled on the `sel_start` cycle.
- `spi_q_oe` rises with `sel_start` and falls with `sel_end`.

## Configuration
- Macro `FLASH_RESP_STATUS_EN` defined:
  - If the first received byte of a frame is 8'h05 (READ STATUS), every subsequent reply byte in that frame is loaded from `status` instead of `tx_data`.
  - `status` is sampled at each byte boundary, so its value can change byte to byte.
  - `rx_valid` still pulses for every byte.
  - A status frame is indicated by an internal `stat_mode` flag, cleared on `sel_start`.
- Macro undefined: `status` is ignored, no `stat_mode` logic is built, and all reply bytes come from `tx_data`.

## Test plan
- Master writes 8'hA5, 8'h3C in one frame → `sel_start` ×1; `rx_valid` ×2 with `rx_data`/`rx_idx` = A5/0 then 3C/1; `sel_end` ×1; `spi_q_oe` high only during the frame.
- `tx_data`=8'h9F at select; `tx_data` updated to 8'h12 after the first `rx_valid`; master reads 2 bytes → master sees 9F then 12.
- `s_n` raised after 5 bits → no `rx_valid`, `sel_end` pulses; next frame sending 8'h81 → `rx_data`=81, `rx_idx`=0.
- Reset asserted mid-frame at bit 3 and released while `s_n`=0, then 8 clocks sent → no `sel_start`, no `rx_valid`, `spi_q_oe`=0; after the `s_n` high→low cycle, normal operation resumes.
- 300-byte frame → `rx_idx` runs 0..255 then holds 255 for the remaining bytes.
- With `FLASH_RESP_STATUS_EN`, `status`=8'h03, `tx_data`=8'hEE: master sends 05 then reads 2 bytes → 03, 03. Repeated without the macro → EE, EE.
